// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier product path.
// Contents: product word width, product buffer depth, and the product,
// buffer-count and buffer-pointer types used by the buffer and its bus.
package booth_pkg;
  localparam int WIDTH_FP  = 32;
  localparam int BUF_DEPTH = 4;   // power of two, at least 2
  localparam int PTR_W     = $clog2(BUF_DEPTH);

  typedef logic [WIDTH_FP-1:0] product_t;
  typedef logic [PTR_W:0]      buf_cnt_t;   // holds 0..BUF_DEPTH
  typedef logic [PTR_W-1:0]    buf_ptr_t;
endpackage

// File: rtl/booth_product_buffer_if.sv
// Bus between the product buffer and its producer/consumer.
// Producer side : product_in, product_valid (pulse), in_ready (space flag).
// Consumer side : product_o, valid_o, ready_i (valid/ready handshake).
// Status        : count_o (stored products), overflow_o (sticky drop flag).
// master = the environment driving products and ready; slave = the buffer.
interface booth_product_buffer_if;
  import booth_pkg::*;

  product_t product_in;
  logic     product_valid;
  logic     in_ready;
  product_t product_o;
  logic     valid_o;
  logic     ready_i;
  buf_cnt_t count_o;
  logic     overflow_o;

  modport master (
    output product_in, product_valid, ready_i,
    input  in_ready, product_o, valid_o, count_o, overflow_o
  );

  modport slave (
    input  product_in, product_valid, ready_i,
    output in_ready, product_o, valid_o, count_o, overflow_o
  );
endinterface

// File: rtl/wrap_pointer.sv
// PTR_W-bit buffer pointer with an increment enable.
// Ports: clk, reset (synchronous, active-high), inc_i (advance by one),
// ptr_o (current pointer). Wraps from 2**PTR_W-1 to 0 by natural overflow,
// which equals wrapping at DEPTH because DEPTH is a power of two.
module wrap_pointer #(
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  output logic [PTR_W-1:0] ptr_o
);
  logic [PTR_W-1:0] ptr_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (inc_i) begin
      ptr_q <= ptr_q + PTR_W'(1);
    end
  end

  assign ptr_o = ptr_q;
endmodule

// File: rtl/booth_product_buffer.sv
// First-word-fall-through buffer for finished Booth products.
// Ports: clk, reset (synchronous, active-high), bus (slave modport):
//   product_in/product_valid  capture a finished product (one-cycle pulse)
//   in_ready                  at least one free slot (from registered count)
//   product_o/valid_o/ready_i head-of-queue handshake to the consumer
//   count_o                   stored products, 0..DEPTH
//   overflow_o                sticky: a product was dropped while full
module booth_product_buffer
  import booth_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  booth_product_buffer_if.slave bus
);
  localparam int DEPTH = BUF_DEPTH;

  buf_ptr_t wptr;
  buf_ptr_t rptr;
  buf_cnt_t count_q, count_d;
  logic     overflow_q, overflow_d;
  product_t mem_q [DEPTH];

  logic full;
  logic not_empty;
  logic pop;
  logic push;

  assign full      = (count_q == buf_cnt_t'(DEPTH));
  assign not_empty = (count_q != '0);
  assign pop       = not_empty && bus.ready_i;
  // A full buffer still accepts a product when the head leaves this cycle.
  assign push      = bus.product_valid && (!full || pop);

  wrap_pointer #(.PTR_W(PTR_W)) u_wptr (
    .clk   (clk),
    .reset (reset),
    .inc_i (push),
    .ptr_o (wptr)
  );

  wrap_pointer #(.PTR_W(PTR_W)) u_rptr (
    .clk   (clk),
    .reset (reset),
    .inc_i (pop),
    .ptr_o (rptr)
  );

  // NOTE: the storage array is deliberately not reset; stale words are
  // never observable because valid_o is derived from the (reset) count.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[wptr] <= bus.product_in;
    end
  end

  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push && !pop) begin
      count_d = count_q + buf_cnt_t'(1);
    end else if (pop && !push) begin
      count_d = count_q - buf_cnt_t'(1);
    end
    if (bus.product_valid && !push) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.valid_o    = not_empty;
  assign bus.product_o  = not_empty ? mem_q[rptr] : '0;
  assign bus.in_ready   = !full;
  assign bus.count_o    = count_q;
  assign bus.overflow_o = overflow_q;
endmodule

// File: tb/tb_booth_product_buffer.sv
// Self-checking bench for booth_product_buffer: a table of one-cycle
// vectors with hand-derived expected state, a scoreboard queue checking
// every pop, and a random-backpressure wrap-around sequence.
module tb_booth_product_buffer;
  import booth_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  booth_product_buffer_if bus ();

  booth_product_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  // Scoreboard: expected products queued on accepted pushes, compared on pops.
  product_t sb[$];
  logic     m_ovf = 1'b0;
  int       pops  = 0;

  always @(posedge clk) begin
    if (reset) begin
      sb.delete();
      m_ovf = 1'b0;
    end else begin
      if (bus.valid_o && bus.ready_i) begin
        pops++;
        if (sb.size() == 0) check("pop_unexpected", 32'd1, 32'd0);
        else check("pop_data", bus.product_o, sb.pop_front());
      end
      if (bus.product_valid) begin
        if (sb.size() < BUF_DEPTH) sb.push_back(bus.product_in);
        else m_ovf = 1'b1;
      end
    end
  end

  typedef struct {
    logic     rst;
    logic     pv;
    product_t din;
    logic     rdy;
    int       exp_cnt;
    logic     exp_v;
    product_t exp_p;
    logic     exp_ir;
    logic     exp_ov;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic pv, product_t din, logic rdy,
                              int cnt, logic v, product_t p, logic ir, logic ov);
    vec_t r;
    r.rst = rst; r.pv = pv; r.din = din; r.rdy = rdy;
    r.exp_cnt = cnt; r.exp_v = v; r.exp_p = p; r.exp_ir = ir; r.exp_ov = ov;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input int cnt, input logic v,
                             input product_t p, input logic ir, input logic ov);
    check({tag, " count"},    32'(bus.count_o), 32'(cnt));
    check({tag, " valid"},    32'(bus.valid_o), 32'(v));
    check({tag, " product"},  bus.product_o, p);
    check({tag, " in_ready"}, 32'(bus.in_ready), 32'(ir));
    check({tag, " overflow"}, 32'(bus.overflow_o), 32'(ov));
  endtask

  initial begin
    reset = 1'b1;
    bus.product_valid = 1'b0;
    bus.product_in = '0;
    bus.ready_i = 1'b0;

    // rst pv din rdy | count valid product in_ready overflow (after the edge)
    // Single product, consumer ready.
    vecs.push_back(mk(1, 0, 0,            0, 0, 0, 0,            1, 0));
    vecs.push_back(mk(0, 1, 32'h0000_0F3C, 1, 1, 1, 32'h0000_0F3C, 1, 0));
    vecs.push_back(mk(0, 0, 0,            1, 0, 0, 0,            1, 0));
    // Fill with backpressure, overflow, hold, drain.
    vecs.push_back(mk(0, 1, 32'h1,        0, 1, 1, 32'h1,        1, 0));
    vecs.push_back(mk(0, 1, 32'h2,        0, 2, 1, 32'h1,        1, 0));
    vecs.push_back(mk(0, 1, 32'h3,        0, 3, 1, 32'h1,        1, 0));
    vecs.push_back(mk(0, 1, 32'h4,        0, 4, 1, 32'h1,        0, 0));
    vecs.push_back(mk(0, 1, 32'hDEAD_BEEF, 0, 4, 1, 32'h1,        0, 1));
    vecs.push_back(mk(0, 0, 0,            0, 4, 1, 32'h1,        0, 1));
    vecs.push_back(mk(0, 0, 0,            1, 3, 1, 32'h2,        1, 1));
    vecs.push_back(mk(0, 0, 0,            1, 2, 1, 32'h3,        1, 1));
    vecs.push_back(mk(0, 0, 0,            1, 1, 1, 32'h4,        1, 1));
    vecs.push_back(mk(0, 0, 0,            1, 0, 0, 0,            1, 1));
    // Simultaneous push and pop while full.
    vecs.push_back(mk(1, 0, 0,            0, 0, 0, 0,            1, 0));
    vecs.push_back(mk(0, 1, 32'h11,       0, 1, 1, 32'h11,       1, 0));
    vecs.push_back(mk(0, 1, 32'h12,       0, 2, 1, 32'h11,       1, 0));
    vecs.push_back(mk(0, 1, 32'h13,       0, 3, 1, 32'h11,       1, 0));
    vecs.push_back(mk(0, 1, 32'h14,       0, 4, 1, 32'h11,       0, 0));
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFE, 1, 4, 1, 32'h12,       0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 3, 1, 32'h13,       1, 0));
    vecs.push_back(mk(0, 0, 0,            1, 2, 1, 32'h14,       1, 0));
    vecs.push_back(mk(0, 0, 0,            1, 1, 1, 32'hFFFF_FFFE, 1, 0));
    vecs.push_back(mk(0, 0, 0,            1, 0, 0, 0,            1, 0));
    // Reset mid-operation: 3 stored with overflow set, then reset.
    vecs.push_back(mk(0, 1, 32'h21,       0, 1, 1, 32'h21,       1, 0));
    vecs.push_back(mk(0, 1, 32'h22,       0, 2, 1, 32'h21,       1, 0));
    vecs.push_back(mk(0, 1, 32'h23,       0, 3, 1, 32'h21,       1, 0));
    vecs.push_back(mk(0, 1, 32'h24,       0, 4, 1, 32'h21,       0, 0));
    vecs.push_back(mk(0, 1, 32'h25,       0, 4, 1, 32'h21,       0, 1));
    vecs.push_back(mk(0, 0, 0,            1, 3, 1, 32'h22,       1, 1));
    vecs.push_back(mk(1, 0, 0,            1, 0, 0, 0,            1, 0));
    vecs.push_back(mk(0, 1, 32'h5,        0, 1, 1, 32'h5,        1, 0));
    vecs.push_back(mk(0, 0, 0,            0, 1, 1, 32'h5,        1, 0));
    vecs.push_back(mk(0, 0, 0,            1, 0, 0, 0,            1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      reset             = vecs[i].rst;
      bus.product_valid = vecs[i].pv;
      bus.product_in    = vecs[i].din;
      bus.ready_i       = vecs[i].rdy;
      tick();
      check_state($sformatf("row%0d", i), vecs[i].exp_cnt, vecs[i].exp_v,
                  vecs[i].exp_p, vecs[i].exp_ir, vecs[i].exp_ov);
    end

    // Wrap-around with random backpressure: 0x10..0x19 must emerge in order.
    reset = 1'b1;
    bus.product_valid = 1'b0;
    bus.ready_i = 1'b0;
    tick();
    reset = 1'b0;
    pops = 0;
    begin
      int sent = 0;
      int cyc  = 0;
      while ((sent < 10 || sb.size() != 0) && cyc < 400) begin
        bus.product_valid = (sent < 10) && bus.in_ready && ($urandom_range(0, 1) == 1);
        bus.product_in    = 32'h10 + 32'(sent);
        if (bus.product_valid) sent++;
        bus.ready_i = ($urandom_range(0, 2) != 0);
        tick();
        check("wrap count", 32'(bus.count_o), 32'(sb.size()));
        check("wrap overflow", 32'(bus.overflow_o), 32'(m_ovf));
        if (sb.size() != 0) check("wrap head", bus.product_o, sb[0]);
        cyc++;
      end
      bus.product_valid = 1'b0;
      bus.ready_i = 1'b0;
      check("wrap all sent", 32'(sent), 32'd10);
      check("wrap pops", 32'(pops), 32'd10);
      check("wrap drained", 32'(bus.valid_o), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
